// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: forwarding-select encodings and shadow-stage layout.
package cpu_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int DEFAULT_CNT_W      = 32;

  localparam int FWD_SEL_W = 2;
  localparam logic [FWD_SEL_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_SEL_W-1:0] FWD_EXMEM   = 2'b01;
  localparam logic [FWD_SEL_W-1:0] FWD_MEMWB   = 2'b10;

  // Destination metadata tracked per shadow stage at the default register width.
  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic                          reg_write;
    logic                          mem_read;
  } shadow_t;

  localparam int SHADOW_W = $bits(shadow_t);

endpackage

// File: rtl/hazard_shadow_stage.sv
// One stage of destination-register shadow state (valid, rd, reg_write, mem_read).
module hazard_shadow_stage
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_enable,
  input  logic                  i_bubble,
  input  logic                  i_valid,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_mem_read,
  output logic                  o_valid,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_wr_active,
  output logic                  o_load
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid     <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (i_enable) begin
      if (i_bubble) begin
        r_valid     <= 1'b0;
        r_rd        <= '0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
      end else begin
        r_valid     <= i_valid;
        r_rd        <= i_rd;
        r_reg_write <= i_reg_write;
        r_mem_read  <= i_mem_read;
      end
    end
  end

  assign o_valid     = r_valid;
  assign o_rd        = r_rd;
  assign o_reg_write = r_reg_write;
  assign o_mem_read  = r_mem_read;
  // x0 is hardwired zero, so a write to it never produces a value anyone depends on.
  assign o_wr_active = r_valid && r_reg_write && (r_rd != '0);
  assign o_load      = r_valid && r_mem_read;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding control for the 5-stage pipeline: stalls, flushes, WB bypass, EX forward selects.
// Optional macro HAZARD_FORWARDING_EN enables EX forwarding; without it every RAW hazard stalls.
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_redirect,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_wb_bypass_1,
  output logic                  id_wb_bypass_2,
  output logic [FWD_SEL_W-1:0]  ex_fwd_sel_a,
  output logic [FWD_SEL_W-1:0]  ex_fwd_sel_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] L_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                  w_ex_valid, w_ex_reg_write, w_ex_mem_read, w_ex_wr, w_ex_load;
  logic [REG_ADDR_W-1:0] w_ex_rd;
  logic                  w_mem_valid, w_mem_reg_write, w_mem_mem_read, w_mem_wr, w_mem_load;
  logic [REG_ADDR_W-1:0] w_mem_rd;
  logic                  w_wb_valid, w_wb_reg_write, w_wb_mem_read, w_wb_wr, w_wb_load;
  logic [REG_ADDR_W-1:0] w_wb_rd;

  logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;
  logic w_hazard, w_stall, w_bubble;
  logic w_unused;

  logic [CNT_W-1:0] r_stall_count, r_flush_count;

  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_ex_stage (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_enable    (enable),
    .i_bubble    (w_bubble),
    .i_valid     (1'b1),
    .i_rd        (id_rd),
    .i_reg_write (id_reg_write),
    .i_mem_read  (id_mem_read),
    .o_valid     (w_ex_valid),
    .o_rd        (w_ex_rd),
    .o_reg_write (w_ex_reg_write),
    .o_mem_read  (w_ex_mem_read),
    .o_wr_active (w_ex_wr),
    .o_load      (w_ex_load)
  );

  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_mem_stage (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_enable    (enable),
    .i_bubble    (1'b0),
    .i_valid     (w_ex_valid),
    .i_rd        (w_ex_rd),
    .i_reg_write (w_ex_reg_write),
    .i_mem_read  (w_ex_mem_read),
    .o_valid     (w_mem_valid),
    .o_rd        (w_mem_rd),
    .o_reg_write (w_mem_reg_write),
    .o_mem_read  (w_mem_mem_read),
    .o_wr_active (w_mem_wr),
    .o_load      (w_mem_load)
  );

  hazard_shadow_stage #(.REG_ADDR_W(REG_ADDR_W)) u_wb_stage (
    .clk         (clk),
    .arst_n      (arst_n),
    .i_enable    (enable),
    .i_bubble    (1'b0),
    .i_valid     (w_mem_valid),
    .i_rd        (w_mem_rd),
    .i_reg_write (w_mem_reg_write),
    .i_mem_read  (w_mem_mem_read),
    .o_valid     (w_wb_valid),
    .o_rd        (w_wb_rd),
    .o_reg_write (w_wb_reg_write),
    .o_mem_read  (w_wb_mem_read),
    .o_wr_active (w_wb_wr),
    .o_load      (w_wb_load)
  );

  assign w_ex_hit1  = id_rs1_used && w_ex_wr  && (w_ex_rd  == id_rs1);
  assign w_ex_hit2  = id_rs2_used && w_ex_wr  && (w_ex_rd  == id_rs2);
  assign w_mem_hit1 = id_rs1_used && w_mem_wr && (w_mem_rd == id_rs1);
  assign w_mem_hit2 = id_rs2_used && w_mem_wr && (w_mem_rd == id_rs2);
  assign w_wb_hit1  = id_rs1_used && w_wb_wr  && (w_wb_rd  == id_rs1);
  assign w_wb_hit2  = id_rs2_used && w_wb_wr  && (w_wb_rd  == id_rs2);

`ifdef HAZARD_FORWARDING_EN
  assign w_hazard = w_ex_load && (w_ex_hit1 || w_ex_hit2);
  assign w_unused = ^{w_mem_load, w_wb_valid, w_wb_reg_write, w_wb_mem_read, w_wb_load};
`else
  assign w_hazard = w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
  assign w_unused = ^{w_ex_load, w_mem_load, w_wb_valid, w_wb_reg_write, w_wb_mem_read, w_wb_load};
`endif

  // A redirect kills the stalled consumer anyway, so it overrides the stall.
  assign w_stall  = w_hazard && !ex_redirect;
  assign w_bubble = w_stall || ex_redirect;

  assign pc_hold        = w_stall;
  assign if_id_hold     = w_stall;
  assign if_id_flush    = ex_redirect;
  assign id_ex_bubble   = w_bubble;
  assign id_wb_bypass_1 = w_wb_hit1;
  assign id_wb_bypass_2 = w_wb_hit2;

`ifdef HAZARD_FORWARDING_EN
  logic [FWD_SEL_W-1:0] r_fwd_sel_a, r_fwd_sel_b;
  logic [FWD_SEL_W-1:0] w_fwd_next_a, w_fwd_next_b;

  function automatic logic [FWD_SEL_W-1:0] pick_fwd(input logic ex_hit, input logic mem_hit,
                                                    input logic ex_load);
    logic [FWD_SEL_W-1:0] sel;
    sel = FWD_REGFILE;
    if (ex_hit && !ex_load) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

  // Today's ex/mem shadows are tomorrow's MEM/WB when the ID instruction reaches EX.
  always_comb begin
    w_fwd_next_a = FWD_REGFILE;
    w_fwd_next_b = FWD_REGFILE;
    if (!w_bubble) begin
      w_fwd_next_a = pick_fwd(w_ex_hit1, w_mem_hit1, w_ex_load);
      w_fwd_next_b = pick_fwd(w_ex_hit2, w_mem_hit2, w_ex_load);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_fwd_sel_a <= FWD_REGFILE;
      r_fwd_sel_b <= FWD_REGFILE;
    end else if (enable) begin
      r_fwd_sel_a <= w_fwd_next_a;
      r_fwd_sel_b <= w_fwd_next_b;
    end
  end

  assign ex_fwd_sel_a = r_fwd_sel_a;
  assign ex_fwd_sel_b = r_fwd_sel_b;
`else
  assign ex_fwd_sel_a = FWD_REGFILE;
  assign ex_fwd_sel_b = FWD_REGFILE;
`endif

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (enable) begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + L_CNT_ONE;
      end
      if (ex_redirect && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + L_CNT_ONE;
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Pipeline control block for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination-register metadata for the EX, MEM and WB stages.
- From that state it generates load-use stalls, branch/jump flushes and registered EX-stage forwarding selects.
- Instantiated once beside the pipeline registers; drives their enable and clear inputs and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register index width (number of architectural registers = 2**REG_ADDR_W; index 0 is hardwired zero).
CNT_W, 32, width of the saturating stall/flush performance counters.

Ports:
clk  input  1  main clock
arst_n  input  1  asynchronous active-low reset
enable  input  1  global pipeline advance; low freezes all state
id_rs1  input  REG_ADDR_W  source 1 index of the instruction in ID
id_rs2  input  REG_ADDR_W  source 2 index of the instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_W  destination index of the ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
ex_redirect  input  1  branch taken or jump resolved in EX this cycle
pc_hold  output  1  hold the PC
if_id_hold  output  1  hold the IF/ID register
if_id_flush  output  1  load a NOP into IF/ID
id_ex_bubble  output  1  load a bubble (all control signals 0) into ID/EX
id_wb_bypass_1  output  1  ID/EX rdata_1 takes the WB write data instead of the regfile output
id_wb_bypass_2  output  1  same, for rdata_2
ex_fwd_sel_a  output  2  EX operand A source: 00 = ID/EX, 01 = EX/MEM alu_out, 10 = MEM/WB write data
ex_fwd_sel_b  output  2  EX operand B source, same encoding
stall_count  output  CNT_W  load-use stall cycles
flush_count  output  CNT_W  redirect events

Behaviour:
- Shadow state: per stage S in {ex, mem, wb}, registers {S_valid, S_rd, S_reg_write, S_mem_read}.
- A stage "writes r" when S_valid && S_reg_write && S_rd == r && r != 0.
- Reset (asynchronous, arst_n low): all shadow valid bits 0, ex_fwd_sel_a/b = 00, counters 0. Combinational outputs then evaluate to 0 unless ex_redirect = 1.
- load_use (combinational): ex_valid && ex_mem_read && ex writes (id_rs1 with id_rs1_used, or id_rs2 with id_rs2_used).
- Redirect (ex_redirect = 1):
  - if_id_flush = 1 and id_ex_bubble = 1.
  - load_use is ignored; redirect has priority.
  - Exactly two younger instructions are killed.
- Stall (load_use && !ex_redirect):
  - pc_hold = if_id_hold = id_ex_bubble = 1.
  - Duration is exactly 1 cycle. Next cycle the load sits in the MEM shadow and the consumer proceeds with forward select 10.
- id_wb_bypass_n = 1 when wb writes id_rsn and id_rsn_used is set. This covers the register file having no write-through.
- Shadow advance on each clk edge with enable = 1:
  - wb <= mem; mem <= ex.
  - ex <= ID fields with valid = 1, unless id_ex_bubble, in which case ex_valid <= 0.
- Forward selects are registered on the same edge, computed against the current ex and mem shadows (they become the MEM and WB stages when the ID instruction enters EX):
  - sel_n <= 01 if ex writes id_rsn, id_rsn_used and !ex_mem_read;
  - else 10 if mem writes id_rsn and id_rsn_used;
  - else 00.
  - The most recent producer wins.
  - sel_n <= 00 when id_ex_bubble.
- enable = 0: all registers hold. Combinational outputs still evaluate; the pipeline ignores them because its registers are gated too.
- Counters, updated only when enable = 1:
  - stall_count +1 per stall cycle; flush_count +1 per redirect cycle.
  - Both saturate at all-ones, no wrap.
- Register index 0 never creates a hazard or a forward.

Optional Feature:
HAZARD_FORWARDING_EN.
- Defined: behaviour as above.
- Undefined: ex_fwd_sel_a/b are tied to 00, and the forwarding registers are removed.
  - The stall condition becomes any RAW hazard against the ex or mem shadow: ex writes or mem writes a used rs1/rs2, regardless of load.
  - Stalls repeat each cycle until the hazard clears.
  - WB bypass and redirect behaviour are unchanged.

Decomposition:
- Shared package cpu_pkg holds: FWD_REGFILE = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10; the shadow-stage struct/field widths; REG_ADDR_W default.
- One natural sub-module: hazard_shadow_stage, one instance per stage. It holds {valid, rd, reg_write, mem_read}, with async reset, enable and a bubble input.

Test Plan:
- Reset, then drive no hazards for 5 cycles -> all outputs 0, counters 0.
- add x5 in EX, ID reads x5 via rs1 -> next cycle ex_fwd_sel_a = 01; sel_b = 00; no stall.
- add x5 in MEM and add x5 in EX simultaneously, ID reads x5 via rs2 -> ex_fwd_sel_b = 01 (youngest producer wins).
- ld x7 in EX, ID reads x7 via rs1 -> pc_hold = if_id_hold = id_ex_bubble = 1 for exactly 1 cycle, stall_count = 1; next cycle ex_fwd_sel_a = 10. Without HAZARD_FORWARDING_EN -> 2 stall cycles, sel stays 00.
- ex_redirect = 1 together with a load-use condition -> if_id_flush = id_ex_bubble = 1, pc_hold = 0, flush_count +1, stall_count unchanged.
- ID writes x0 as a load, next ID reads x0 -> no stall, no forward, no bypass. Then assert arst_n low mid-stall -> all shadows invalid and counters 0 immediately.
